// File: rtl/demux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : demux_dispatcher
// Purpose  : Registered valid/ready front end for a parametric demultiplexer.
//            Beats tagged with a destination index are held in a two-entry
//            skid buffer. The head entry drives BUS_OUT/SEL_OUT and a one-hot
//            OUT_VALID. Ordering is strict FIFO across destinations, so a
//            stalled head blocks all later beats.
// Ports    : CLK, RST (sync, active-high)
//            IN_VALID/IN_READY/IN_DATA/IN_DEST  - upstream beat handshake
//            BUS_OUT/SEL_OUT                    - head beat to demux
//            OUT_VALID/OUT_READY                - per-destination handshake
//            DROP_PULSE/DROP_COUNT              - dropped-beat reporting
// Options  : `DEMUX_DISPATCHER_DEST_CHECK_EN - drop out-of-range beats and
//            count them. When undefined, an out-of-range destination is
//            clamped to NUM_OUTPUTS-1, and the drop outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module demux_dispatcher #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 8,
  parameter int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATA_WIDTH-1:0]  IN_DATA,
  input  logic [SEL_WIDTH-1:0]   IN_DEST,
  output logic [DATA_WIDTH-1:0]  BUS_OUT,
  output logic [SEL_WIDTH-1:0]   SEL_OUT,
  output logic [NUM_OUTPUTS-1:0] OUT_VALID,
  input  logic [NUM_OUTPUTS-1:0] OUT_READY,
  output logic                   DROP_PULSE,
  output logic [7:0]             DROP_COUNT
);

  // One extra bit so NUM_OUTPUTS itself is representable in the compare.
  localparam logic [SEL_WIDTH:0]   c_num_outputs = (SEL_WIDTH+1)'(NUM_OUTPUTS);
  localparam logic [SEL_WIDTH-1:0] c_max_sel     = SEL_WIDTH'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_WIDTH-1:0]    head_sel_q, head_sel_d;
  logic [SEL_WIDTH-1:0]    skid_sel_q, skid_sel_d;
  logic                    in_ready_q, in_ready_d;

  logic                    w_accept;
  logic                    w_complete;
  logic                    w_oor;
  logic                    w_drop;
  logic                    w_store;
  logic [SEL_WIDTH-1:0]    w_dest;

  assign w_accept   = IN_VALID && in_ready_q;
  // Only the ready bit addressed by the head matters.
  assign w_complete = (state_q != ST_EMPTY) && OUT_READY[head_sel_q];
  assign w_oor      = ({1'b0, IN_DEST} >= c_num_outputs);

`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
  assign w_drop = w_accept && w_oor;
  assign w_dest = IN_DEST;
`else
  assign w_drop = 1'b0;
  assign w_dest = w_oor ? c_max_sel : IN_DEST;
`endif

  // A dropped beat is consumed upstream but never enters the buffer.
  assign w_store = w_accept && !w_drop;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_store) begin
          head_data_d = IN_DATA;
          head_sel_d  = w_dest;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_store && w_complete) begin
          head_data_d = IN_DATA;
          head_sel_d  = w_dest;
        end else if (w_store) begin
          skid_data_d = IN_DATA;
          skid_sel_d  = w_dest;
          state_d     = ST_FULL;
        end else if (w_complete) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_complete) begin
          head_data_d = skid_data_q;
          head_sel_d  = skid_sel_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready: looks ahead at the next state so no path from
    // OUT_READY reaches IN_READY combinationally.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    OUT_VALID = '0;
    if (state_q != ST_EMPTY) begin
      OUT_VALID[head_sel_q] = 1'b1;
    end
  end

  // Head register is never cleared on completion, so in EMPTY the outputs
  // keep showing the last completed beat.
  assign IN_READY = in_ready_q;
  assign BUS_OUT  = head_data_q;
  assign SEL_OUT  = head_sel_q;

`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
  logic       drop_pulse_q, drop_pulse_d;
  logic [7:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_pulse_d = w_drop;
    drop_count_d = drop_count_q;
    if (w_drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign DROP_PULSE = drop_pulse_q;
  assign DROP_COUNT = drop_count_q;
`else
  assign DROP_PULSE = 1'b0;
  assign DROP_COUNT = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_dispatcher
// Purpose  : Self-checking bench for demux_dispatcher. Two instances share
//            stimulus: NUM_OUTPUTS=8 (power of two) and NUM_OUTPUTS=6 (has
//            out-of-range destinations). Each is compared every cycle with a
//            two-deep FIFO reference model, plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_dispatcher;

`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
  localparam bit DEST_CHECK = 1'b1;
`else
  localparam bit DEST_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  in_dest = '0;
  logic [7:0]  out_ready = '0;

  logic        rdy8, rdy6, dp8, dp6;
  logic [15:0] bus8, bus6;
  logic [2:0]  sel8, sel6;
  logic [7:0]  ov8, dc8, dc6;
  logic [5:0]  ov6;

  always #5 clk = ~clk;

  demux_dispatcher #(.DATA_WIDTH(16), .NUM_OUTPUTS(8)) u_dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy8),
    .IN_DATA(in_data), .IN_DEST(in_dest), .BUS_OUT(bus8), .SEL_OUT(sel8),
    .OUT_VALID(ov8), .OUT_READY(out_ready), .DROP_PULSE(dp8), .DROP_COUNT(dc8)
  );

  demux_dispatcher #(.DATA_WIDTH(16), .NUM_OUTPUTS(6)) u_dut6 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy6),
    .IN_DATA(in_data), .IN_DEST(in_dest), .BUS_OUT(bus6), .SEL_OUT(sel6),
    .OUT_VALID(ov6), .OUT_READY(out_ready[5:0]), .DROP_PULSE(dp6), .DROP_COUNT(dc6)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: index 0 = 8-output instance, 1 = 6-output instance.
  logic [15:0] m_data [2][2];
  logic [2:0]  m_sel  [2][2];
  int          m_cnt  [2] = '{0, 0};
  logic        m_rdy  [2] = '{1'b0, 1'b0};
  logic [15:0] m_bus  [2] = '{16'd0, 16'd0};
  logic [2:0]  m_selo [2] = '{3'd0, 3'd0};
  logic        m_dp   [2] = '{1'b0, 1'b0};
  int          m_dc   [2] = '{0, 0};

  task automatic model_step(input int k);
    int          n;
    logic [2:0]  d;
    logic        comp, acc, drop;
    n = (k == 0) ? 8 : 6;
    if (rst) begin
      m_cnt[k] = 0; m_rdy[k] = 1'b0; m_bus[k] = '0; m_selo[k] = '0;
      m_dp[k] = 1'b0; m_dc[k] = 0;
      return;
    end
    comp = (m_cnt[k] > 0) && out_ready[m_sel[k][0]];
    acc  = in_valid && m_rdy[k];
    d    = in_dest;
    drop = 1'b0;
    if (int'(in_dest) >= n) begin
      if (DEST_CHECK) drop = 1'b1;
      else            d = 3'(n - 1);
    end
    m_dp[k] = acc && drop;
    if (acc && drop && m_dc[k] < 255) m_dc[k]++;
    if (comp) begin
      m_data[k][0] = m_data[k][1];
      m_sel[k][0]  = m_sel[k][1];
      m_cnt[k]--;
    end
    if (acc && !drop) begin
      m_data[k][m_cnt[k]] = in_data;
      m_sel[k][m_cnt[k]]  = d;
      m_cnt[k]++;
    end
    m_rdy[k] = (m_cnt[k] < 2);
    if (m_cnt[k] > 0) begin
      m_bus[k]  = m_data[k][0];
      m_selo[k] = m_sel[k][0];
    end
  endtask

  function automatic logic [7:0] exp_ov(input int k);
    return (m_cnt[k] > 0) ? (8'd1 << m_sel[k][0]) : 8'd0;
  endfunction

  task automatic compare_all();
    check_val("in_ready8",   rdy8, m_rdy[0]);
    check_val("out_valid8",  ov8,  exp_ov(0));
    check_val("bus_out8",    bus8, m_bus[0]);
    check_val("sel_out8",    sel8, m_selo[0]);
    check_val("drop_pulse8", dp8,  m_dp[0]);
    check_val("drop_count8", dc8,  m_dc[0]);
    check_val("in_ready6",   rdy6, m_rdy[1]);
    check_val("out_valid6",  ov6,  exp_ov(1));
    check_val("bus_out6",    bus6, m_bus[1]);
    check_val("sel_out6",    sel6, m_selo[1]);
    check_val("drop_pulse6", dp6,  m_dp[1]);
    check_val("drop_count6", dc6,  m_dc[1]);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [15:0] data,
                       input logic [2:0] dest, input logic [7:0] ordy);
    @(negedge clk);
    rst = r; in_valid = v; in_data = data; in_dest = dest; out_ready = ordy;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset values
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 3'd0, 8'hFF);
      check_val("rst_in_ready", rdy8, 0);
      check_val("rst_out_valid", ov8, 0);
      check_val("rst_bus", bus8, 0);
      check_val("rst_drop_count", dc6, 0);
    end
    cycle(1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
    check_val("rel_in_ready8", rdy8, 1);
    check_val("rel_in_ready6", rdy6, 1);

    // Streaming, one beat per cycle, accept+complete overlap on each edge
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 16'h1000 + 16'(i), 3'(i), 8'hFF);
      check_val("stream_sel", sel8, i);
      check_val("stream_ov", ov8, 32'(1 << i));
      check_val("stream_bus", bus8, 32'h1000 + i);
      check_val("stream_rdy", rdy8, 1);
    end
    cycle(1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
    check_val("drain_ov", ov8, 0);
    check_val("drain_bus_hold", bus8, 32'h1007);
    check_val("drain_sel_hold", sel8, 7);

    // Head-of-line stall
    cycle(1'b0, 1'b1, 16'hA002, 3'd2, 8'hFB);
    check_val("hol_sel_a", sel8, 2);
    check_val("hol_rdy_a", rdy8, 1);
    cycle(1'b0, 1'b1, 16'hB005, 3'd5, 8'hFB);
    check_val("hol_rdy_full", rdy8, 0);
    check_val("hol_sel_b", sel8, 2);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 16'hC006, 3'd6, 8'hFB);
      check_val("hol_sel_hold", sel8, 2);
      check_val("hol_bus_hold", bus8, 32'hA002);
      check_val("hol_ov_hold", ov8, 32'h04);
    end
    cycle(1'b0, 1'b1, 16'hC006, 3'd6, 8'hFF);
    check_val("rel_sel_5", sel8, 5);
    check_val("rel_bus_5", bus8, 32'hB005);
    check_val("rel_rdy", rdy8, 1);
    cycle(1'b0, 1'b1, 16'hC006, 3'd6, 8'hFF);
    check_val("rel_sel_6", sel8, 6);
    check_val("rel_bus_6", bus8, 32'hC006);
    cycle(1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
    check_val("rel_empty", ov8, 0);

    // Out-of-range destination on the 6-output instance
    cycle(1'b1, 1'b0, 16'h0, 3'd0, 8'hFF);
    cycle(1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
    cycle(1'b0, 1'b1, 16'hBEEF, 3'd7, 8'h00);
`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
    check_val("oor_pulse", dp6, 1);
    check_val("oor_count", dc6, 1);
    check_val("oor_ov", ov6, 0);
`else
    check_val("oor_sel", sel6, 5);
    check_val("oor_ov", ov6, 32'h20);
    check_val("oor_bus", bus6, 32'hBEEF);
`endif
    cycle(1'b0, 1'b0, 16'h0, 3'd0, 8'hFF);
    check_val("oor_pulse_end", dp6, 0);
`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
    check_val("oor_count_hold", dc6, 1);
`else
    check_val("oor_count_zero", dc6, 0);
`endif

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 16'(i), 3'd7, 8'hFF);
    end
`ifdef DEMUX_DISPATCHER_DEST_CHECK_EN
    check_val("sat_count", dc6, 255);
`else
    check_val("sat_count", dc6, 0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic        r, v;
      logic [7:0]  o;
      r = ($urandom_range(0, 199) == 0);
      v = 1'($urandom);
      o = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cycle(r, v, 16'($urandom), 3'($urandom_range(0, 7)), o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_dispatcher.md
# demux_dispatcher

Registered valid/ready front end for the parametric demultiplexer. It accepts a stream of data beats, each tagged with a destination index. It drives the demux's data and select inputs from a two-entry skid buffer, and raises a one-hot per-output valid so each consumer sees only its own beats. It sits directly upstream of the demux, and its `BUS_OUT`/`SEL_OUT` connect straight to the demux `BUS_IN`/`SEL_IN`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, beat width in bits
- `NUM_OUTPUTS`, 8, number of destinations; need not be a power of two; must be ≥2
- `SEL_WIDTH`, `$clog2(NUM_OUTPUTS)`, derived; do not override

Ports:
- `CLK`  in  1  single clock, all logic on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `IN_VALID`  in  1  upstream beat valid
- `IN_READY`  out  1  dispatcher can accept; registered
- `IN_DATA`  in  DATA_WIDTH  beat payload
- `IN_DEST`  in  SEL_WIDTH  destination index
- `BUS_OUT`  out  DATA_WIDTH  head-beat payload; connects to demux `BUS_IN`
- `SEL_OUT`  out  SEL_WIDTH  head-beat destination; connects to demux `SEL_IN`
- `OUT_VALID`  out  NUM_OUTPUTS  one-hot; bit `SEL_OUT` is set while the head beat is valid
- `OUT_READY`  in  NUM_OUTPUTS  per-destination ready
- `DROP_PULSE`  out  1  one-cycle pulse per dropped beat (see Configuration)
- `DROP_COUNT`  out  8  saturating count of dropped beats

## Operation
- Input handshake: a beat is accepted on any cycle with `IN_VALID && IN_READY`.
- Output handshake: a beat completes on any cycle with `|(OUT_VALID & OUT_READY)`. Only the `OUT_READY` bit at `SEL_OUT` matters; all other ready bits are ignored.
- Storage: a main register, which is the head driving the outputs, plus a skid register.
- Buffer states:
  - EMPTY: no beats held.
  - ONE: head valid, skid empty.
  - FULL: head and skid both valid.
- State transitions:
  - EMPTY, accept → ONE.
  - ONE, accept and no complete → FULL.
  - ONE, complete and no accept → EMPTY.
  - ONE, accept and complete together → ONE; the new beat is loaded into the head.
  - FULL, complete → ONE; the skid beat moves into the head.
  - FULL never accepts.
- `IN_READY` is 1 in EMPTY and ONE, and 0 in FULL. It is computed from the registered state, so there is no combinational path from `OUT_READY` to `IN_READY`.
- Ordering is strict FIFO across all destinations. A stalled head blocks every later beat, including beats for other destinations; this head-of-line blocking is intended.
- While the head is stalled, `BUS_OUT`, `SEL_OUT` and `OUT_VALID` hold stable.
- In EMPTY, `OUT_VALID` is all zeros. `BUS_OUT` and `SEL_OUT` hold the last completed beat, or 0 if no beat has completed since reset.
- Out-of-range destination (`IN_DEST >= NUM_OUTPUTS`) is handled as set by the Configuration section.

## Timing
- Reset (`RST` high at a clock edge) forces, on that edge:
  - state to EMPTY;
  - `IN_READY`=0 while `RST` is high, then 1 on the first cycle after `RST` is low;
  - `OUT_VALID`=0, `BUS_OUT`=0, `SEL_OUT`=0;
  - `DROP_PULSE`=0, `DROP_COUNT`=0.
- Reset mid-transfer discards both held beats with no output handshake.
- Latency: a beat accepted at edge N appears on the outputs after edge N, i.e. one cycle.
- Throughput: one beat per cycle when `OUT_READY[SEL_OUT]` is held high.
- `IN_READY` falls in the cycle after the buffer becomes FULL. It rises in the cycle after the completing handshake.

## Configuration
- Macro: `DEMUX_DISPATCHER_DEST_CHECK_EN`.
- Defined:
  - A beat with `IN_DEST >= NUM_OUTPUTS` is still accepted normally, so `IN_READY` governs it like any other beat.
  - The beat is never stored or presented on the outputs.
  - `DROP_PULSE` is 1 for the cycle after acceptance.
  - `DROP_COUNT` increments and saturates at 255.
  - A dropped beat does not change the buffer state.
- Not defined:
  - An out-of-range destination is clamped to `NUM_OUTPUTS-1` and delivered there.
  - `DROP_PULSE` and `DROP_COUNT` are tied to 0.
- With a power-of-two `NUM_OUTPUTS` the two builds behave identically.

## Test plan
- **Reset values:** hold `RST` high for 3 cycles, then release. Check that all outputs are 0 during reset, and that `IN_READY` is 1 on the first cycle after release.
- **Streaming:** drive 8 beats with `IN_DATA`=0x1000+i and `IN_DEST`=i, `OUT_READY`=0xFF. Check one beat per cycle and 1-cycle latency. Beat i must show `SEL_OUT`=i, `OUT_VALID`=1<<i, `BUS_OUT`=0x1000+i.
- **Head-of-line stall:** with `OUT_READY`=0xFB, send beats to destinations 2, 5 and 6. Check:
  - `SEL_OUT`=2 and `BUS_OUT` hold stable;
  - `IN_READY` drops after the second beat is accepted;
  - setting `OUT_READY`=0xFF releases the beats in order 2, 5, 6.
- **Simultaneous accept and complete:** in ONE, accept and complete in the same cycle. Check the state stays ONE, the new beat is at the head next cycle, and `IN_READY` stays 1.
- **Out-of-range destination:** use `NUM_OUTPUTS`=6 and `IN_DEST`=7.
  - With the macro: `DROP_PULSE` is a 1-cycle pulse, `DROP_COUNT`=1, and `OUT_VALID` stays 0.
  - Without the macro: the beat is delivered with `SEL_OUT`=5 and `OUT_VALID`=0x20.
- **Drop counter saturation:** with the macro, send 300 out-of-range beats. Check `DROP_COUNT`=255.
